// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Iterative RV32M multiply/divide unit that sits beside the ALU in EX.
// One M-extension op is accepted from EX; the front of the pipeline is
// stalled while the unit iterates one bit per cycle, then result_m is
// presented together with a single-cycle flagM pulse so the EX/MEM register
// captures it instead of the ALU result.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   start     EX holds a valid M op (held until stall drops)
//   funct3E   op select: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   srcA      rs1 operand after forwarding
//   srcB      rs2 operand after forwarding
//   flush     kill the op in EX
//   stall     freezes PC, IF/ID, ID/EX; bubbles EX/MEM
//   busy      unit is not idle
//   flagM     result_m is valid this cycle
//   result_m  final result, held until the next op completes
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3E,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             flagM,
  output logic [WIDTH-1:0] result_m
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  //   hi/lo double as {product high, product low / multiplier} for multiply
  //   and {partial remainder, dividend / quotient} for divide.
  //   opnd holds the multiplicand or the divisor magnitude.
  // ---------------------------------------------------------------------------
  state_t             state_reg,  state_next;
  logic [CNT_W-1:0]   cnt_reg,    cnt_next;
  logic [2:0]         funct3_reg, funct3_next;
  logic [WIDTH-1:0]   opnd_reg,   opnd_next;
  logic [WIDTH-1:0]   hi_reg,     hi_next;
  logic [WIDTH-1:0]   lo_reg,     lo_next;
  logic               neg_q_reg,  neg_q_next;   // negate product / quotient
  logic               neg_r_reg,  neg_r_next;   // negate remainder
  logic [WIDTH-1:0]   result_reg, result_next;

  // ---------------------------------------------------------------------------
  // Incoming op decode (used only in IDLE)
  // ---------------------------------------------------------------------------
  logic             is_div_in;
  logic             signed_a_in;
  logic             signed_b_in;
  logic             neg_a_in;
  logic             neg_b_in;
  logic [WIDTH-1:0] a_mag_in;
  logic [WIDTH-1:0] b_mag_in;
  logic             div_zero_in;
  logic             div_ovf_in;
  logic [WIDTH-1:0] special_res_in;

  always_comb begin
    is_div_in   = funct3E[2];
    // Only MULHU, DIVU and REMU treat rs1 as unsigned.
    signed_a_in = (funct3E != F_MULHU) && (funct3E != F_DIVU) && (funct3E != F_REMU);
    signed_b_in = (funct3E == F_MUL) || (funct3E == F_MULH) ||
                  (funct3E == F_DIV) || (funct3E == F_REM);
    neg_a_in    = signed_a_in && srcA[WIDTH-1];
    neg_b_in    = signed_b_in && srcB[WIDTH-1];
    a_mag_in    = neg_a_in ? -srcA : srcA;
    b_mag_in    = neg_b_in ? -srcB : srcB;

    div_zero_in = is_div_in && (srcB == '0);
    // Signed overflow only for DIV/REM (funct3[0]==0): MIN_NEG / -1.
    div_ovf_in  = is_div_in && !funct3E[0] && (srcA == MIN_NEG) && (srcB == '1);

    // Remainder ops (funct3[1]==1) return the dividend on /0 and 0 on overflow;
    // quotient ops return all-ones on /0 and the dividend (MIN_NEG) on overflow.
    if (funct3E[1]) begin
      special_res_in = div_zero_in ? srcA : '0;
    end else begin
      special_res_in = div_zero_in ? '1 : srcA;
    end
  end

  // ---------------------------------------------------------------------------
  // One iteration step
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  always_comb begin
    // Shift-add: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole {carry, hi, lo} right.
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
    // Restoring divide: bring in the next dividend bit (MSB first) and try
    // subtracting the divisor; the borrow bit decides the quotient bit.
    div_shift = {hi_reg, lo_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_reg};

    if (funct3_reg[2]) begin
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {lo_reg[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {lo_reg[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_reg[WIDTH-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Final result formed from the last step's values, so it can be registered
  // on the same edge that enters DONE.
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_abs;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   final_res;

  always_comb begin
    prod_abs = {step_hi, step_lo};
    prod_fix = neg_q_reg ? -prod_abs : prod_abs;
    final_res = '0;
    case (funct3_reg)
      F_MUL:   final_res = prod_fix[WIDTH-1:0];
      F_DIV:   final_res = neg_q_reg ? -step_lo : step_lo;
      F_DIVU:  final_res = step_lo;
      F_REM:   final_res = neg_r_reg ? -step_hi : step_hi;
      F_REMU:  final_res = step_hi;
      default: final_res = prod_fix[2*WIDTH-1:WIDTH];   // MULH, MULHSU, MULHU
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state / datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    funct3_next = funct3_reg;
    opnd_next   = opnd_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    neg_q_next  = neg_q_reg;
    neg_r_next  = neg_r_reg;
    result_next = result_reg;

    case (state_reg)
      IDLE: begin
        if (start && !flush) begin
          funct3_next = funct3E;
          neg_q_next  = neg_a_in ^ neg_b_in;
          neg_r_next  = neg_a_in;
          cnt_next    = '0;
          hi_next     = '0;
          if (div_zero_in || div_ovf_in) begin
            result_next = special_res_in;
            state_next  = DONE;
          end else begin
            state_next = CALC;
            if (is_div_in) begin
              opnd_next = b_mag_in;
              lo_next   = a_mag_in;
            end else begin
              opnd_next = a_mag_in;
              lo_next   = b_mag_in;
            end
          end
        end
      end

      CALC: begin
        if (flush) begin
          // Abort silently; result_m keeps the previous op's value.
          state_next = IDLE;
        end else begin
          hi_next  = step_hi;
          lo_next  = step_lo;
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == LAST_ITER) begin
            result_next = final_res;
            state_next  = DONE;
          end
        end
      end

      DONE: begin
        // start is ignored here; a new op is taken in the following IDLE cycle.
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      funct3_reg <= '0;
      opnd_reg   <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      funct3_reg <= funct3_next;
      opnd_reg   <= opnd_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      neg_q_reg  <= neg_q_next;
      neg_r_reg  <= neg_r_next;
      result_reg <= result_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. stall is combinational so the pipeline freezes in the very cycle
  // the op is presented; it is forced low while reset is asserted so a held
  // start cannot keep the pipeline frozen during reset.
  // ---------------------------------------------------------------------------
  assign stall    = !rst && (((state_reg == IDLE) && start && !flush) || (state_reg == CALC));
  assign busy     = (state_reg != IDLE);
  assign flagM    = (state_reg == DONE);
  assign result_m = result_reg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for muldiv_sequencer (WIDTH=32).
// A reference model computes each op's result with plain 64-bit arithmetic and
// tracks the expected stall/busy/flagM/result_m timeline as a countdown; a
// compare process checks the DUT against it every cycle. Directed vectors also
// carry hand-computed literal results.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [2:0]   funct3E;
  logic [W-1:0] srcA;
  logic [W-1:0] srcB;
  logic         flush;
  logic         stall;
  logic         busy;
  logic         flagM;
  logic [W-1:0] result_m;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .funct3E  (funct3E),
    .srcA     (srcA),
    .srcB     (srcB),
    .flush    (flush),
    .stall    (stall),
    .busy     (busy),
    .flagM    (flagM),
    .result_m (result_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference arithmetic
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] golden(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint     sa;
    longint     sb;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // ---------------------------------------------------------------------------
  // Timeline model: m_cnt = compute cycles still to go, m_done = result cycle
  // ---------------------------------------------------------------------------
  int          m_cnt  = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_res  = '0;
  logic [31:0] m_pend = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_cnt > 0) begin
      if (flush) begin
        m_cnt <= 0;
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_done <= 1'b1;
          m_res  <= m_pend;
        end
      end
    end else if (start && !flush) begin
      if (is_special(funct3E, srcA, srcB)) begin
        m_done <= 1'b1;
        m_res  <= golden(funct3E, srcA, srcB);
      end else begin
        m_cnt  <= W;
        m_pend <= golden(funct3E, srcA, srcB);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      logic e_idle;
      e_idle = (m_cnt == 0) && !m_done;
      chk("cyc_stall", 32'(stall), 32'(!rst && ((e_idle && start && !flush) || m_cnt > 0)));
      chk("cyc_busy",  32'(busy),  32'((m_cnt > 0) || m_done));
      chk("cyc_flagM", 32'(flagM), 32'(m_done));
      chk("cyc_result", result_m, m_res);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed transaction: present op in the next cycle, hold start, wait for
  // flagM, check the literal result and the number of stall cycles.
  // start is left high so a following call issues back-to-back.
  // ---------------------------------------------------------------------------
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_stall);
    int  n_stall;
    bit  got;
    @(posedge clk); #1;
    start = 1'b1; funct3E = f; srcA = a; srcB = b;
    n_stall = 0;
    got     = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (stall) n_stall++;
      if (flagM) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL op_timeout: no flagM for f3=%0d a=%h b=%h", f, a, b);
    end else begin
      chk("op_result", result_m, exp);
      chk("op_stall_cycles", 32'(n_stall), 32'(exp_stall));
    end
    $display("op f3=%0d a=%h b=%h result_m=%h stall_cycles=%0d", f, a, b, result_m, n_stall);
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    int nflag;
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    funct3E = '0; srcA = '0; srcB = '0;

    // Reset state
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_flagM", 32'(flagM), 32'd0);
    chk("rst_result", result_m, 32'd0);
    @(posedge clk); #1;
    rst    = 1'b0;
    chk_en = 1'b1;

    // Pin the reference arithmetic with hand-computed values
    chk("model_mul",    golden(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    chk("model_mulhsu", golden(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
    chk("model_rem",    golden(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("model_divovf", golden(3'd4, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

    // T1
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    go_idle();
    // T2 back-to-back
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    go_idle();
    // T3
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 33);
    run_op(3'd7, 32'd100, 32'd7, 32'd2, 33);
    run_op(3'd4, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);
    run_op(3'd6, 32'd100, 32'hFFFF_FFF9, 32'd2, 33);
    run_op(3'd0, 32'h0001_0000, 32'h0001_0000, 32'd0, 33);
    run_op(3'd3, 32'h0001_0000, 32'h0001_0000, 32'd1, 33);
    go_idle();
    // T4 divide by zero
    run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op(3'd6, 32'd5, 32'd0, 32'd5, 1);
    go_idle();
    // T5 signed overflow
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    go_idle();
    // Known nonzero result to observe through the flush
    run_op(3'd0, 32'd3, 32'd4, 32'd12, 33);
    go_idle();

    // T6a flush in CALC cycle 10
    @(posedge clk); #1;
    start = 1'b1; funct3E = 3'd0; srcA = 32'd5; srcB = 32'd6;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("flush_stall_in_calc", 32'(stall), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy_after", 32'(busy), 32'd0);
    nflag = 0;
    repeat (40) begin
      @(negedge clk);
      if (flagM) nflag++;
    end
    chk("flush_no_flagM", 32'(nflag), 32'd0);
    chk("flush_result_kept", result_m, 32'd12);
    $display("flush in CALC: flagM pulses=%0d result_m=%h", nflag, result_m);

    // T6b flush with start in IDLE is ignored
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("idle_flush_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("idle_flush_busy", 32'(busy), 32'd0);

    // T6c reset mid-CALC
    @(posedge clk); #1;
    start = 1'b1; funct3E = 3'd5; srcA = 32'd100; srcB = 32'd7;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_stall", 32'(stall), 32'd0);
    chk("midrst_busy",  32'(busy),  32'd0);
    chk("midrst_flagM", 32'(flagM), 32'd0);
    chk("midrst_result", result_m, 32'd0);
    $display("reset mid-CALC: stall=%0d busy=%0d flagM=%0d result_m=%h", stall, busy, flagM, result_m);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;

    // Recovery after reset
    run_op(3'd7, 32'd100, 32'd7, 32'd2, 33);
    go_idle();
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
